// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
// Slot layout mirrors one in-flight instruction in the shadow scoreboard.
package fwd_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b01;
    localparam fwd_sel_t FWD_MEMWB = 2'b10;
    localparam fwd_sel_t FWD_WBLAT = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             regwrite;
        logic             is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // A slot only forwards if it really writes a nonzero register.
    function automatic logic is_producer(input slot_t s);
        return s.valid && s.regwrite && (s.dst != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// Priority compare of one ID source register against the EX/MEM/WB slots.
// Nearest producer wins; also flags a load sitting in EX that feeds this source.
module fwd_sel_calc
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  slot_t            i_ex,
    input  slot_t            i_mem,
    input  slot_t            i_wb,
    output fwd_sel_t         o_sel,
    output logic             o_ex_load_hit
);

    logic w_src_live;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;
    logic w_unused_load_flags;

    assign w_src_live = i_use && (i_src != '0);
    assign w_hit_ex   = w_src_live && is_producer(i_ex)  && (i_ex.dst  == i_src);
    assign w_hit_mem  = w_src_live && is_producer(i_mem) && (i_mem.dst == i_src);
    assign w_hit_wb   = w_src_live && is_producer(i_wb)  && (i_wb.dst  == i_src);

    assign o_ex_load_hit       = w_hit_ex && i_ex.is_load;
    assign w_unused_load_flags = i_mem.is_load ^ i_wb.is_load;

    always_comb begin
        // NOTE: default first, so every path assigns o_sel and no latch is inferred.
        o_sel = FWD_RF;
        if (w_hit_ex)
            o_sel = FWD_EXMEM;
        else if (w_hit_mem)
            o_sel = FWD_MEMWB;
        else if (w_hit_wb)
            o_sel = FWD_WBLAT;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage MIPS pipeline: shadow
// scoreboard, registered EX operand selects, load-use and HI/LO stalls.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             id_muldiv,
    input  logic             id_hilo_rd,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             muldiv_busy
);

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    fwd_sel_t         r_fwd_a;
    fwd_sel_t         r_fwd_b;
    logic [CNT_W-1:0] r_busy_cnt;

    slot_t    w_id_slot;
    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;
    logic     w_ld_hit_a;
    logic     w_ld_hit_b;
    logic     w_busy;
    logic     w_load_use;
    logic     w_hilo_stall;
    logic     w_stall;
    logic     w_issue;

    fwd_sel_calc u_sel_rs (
        .i_src         (id_rs),
        .i_use         (id_use_rs),
        .i_ex          (r_ex),
        .i_mem         (r_mem),
        .i_wb          (r_wb),
        .o_sel         (w_sel_a),
        .o_ex_load_hit (w_ld_hit_a)
    );

    fwd_sel_calc u_sel_rt (
        .i_src         (id_rt),
        .i_use         (id_use_rt),
        .i_ex          (r_ex),
        .i_mem         (r_mem),
        .i_wb          (r_wb),
        .o_sel         (w_sel_b),
        .o_ex_load_hit (w_ld_hit_b)
    );

    assign w_id_slot = '{valid: id_valid, dst: id_dst, regwrite: id_regwrite, is_load: id_is_load};

    assign w_busy       = (r_busy_cnt != '0);
    assign w_load_use   = id_valid && (w_ld_hit_a || w_ld_hit_b);
    assign w_hilo_stall = id_valid && (id_muldiv || id_hilo_rd) && w_busy;
    // A flush kills the ID instruction anyway, and hold freezes everything.
    assign w_stall      = !flush && !hold && (w_load_use || w_hilo_stall);
    assign w_issue      = !hold && id_valid && !w_stall && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex    <= SLOT_BUBBLE;
            r_mem   <= SLOT_BUBBLE;
            r_wb    <= SLOT_BUBBLE;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (!hold) begin
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= w_issue ? w_id_slot : SLOT_BUBBLE;
            r_fwd_a <= w_issue ? w_sel_a   : FWD_RF;
            r_fwd_b <= w_issue ? w_sel_b   : FWD_RF;
        end
    end

    // The HI/LO unit keeps running through a hold, so the counter does too.
    always_ff @(posedge clk) begin
        if (reset)
            r_busy_cnt <= '0;
        else if (w_issue && id_muldiv)
            r_busy_cnt <= CNT_W'(MULDIV_CYCLES);
        else if (w_busy)
            r_busy_cnt <= r_busy_cnt - 1'b1;
    end

    assign stall       = w_stall;
    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign muldiv_busy = w_busy;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage MIPS pipeline.
- Tracks the destinations of in-flight instructions in a shadow scoreboard (EX/MEM/WB slots).
- Produces registered 2-bit forward selects for the two EX-stage operand muxes, and a load-use/mul-div stall for IF/ID.
- Sits beside the ID/EX pipeline register and drives the operand-mux select inputs.

Parameters:
- MULDIV_CYCLES, 32, cycles HI/LO stay busy after a mul/div issues (1..63).
- CNT_W, 6, width of the mul/div busy counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high.
- hold  input  1  global pipeline freeze (e.g. memory wait).
- flush  input  1  kill the ID instruction (taken branch/jump).
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  5  source register A.
- id_rt  input  5  source register B.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_dst  input  5  destination register.
- id_regwrite  input  1  instruction writes id_dst.
- id_is_load  input  1  instruction is a load.
- id_muldiv  input  1  instruction starts a mul/div.
- id_hilo_rd  input  1  instruction reads HI/LO (mfhi/mflo).
- stall  output  1  freeze PC and IF/ID; insert a bubble into EX.
- fwd_a  output  2  operand-A select for the EX instruction.
- fwd_b  output  2  operand-B select for the EX instruction.
- muldiv_busy  output  1  busy counter nonzero.

Behaviour:
- Select encoding, shared by both operand muxes:
  - 00: register-file read data.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB result (load data or ALU).
  - 11: retired write-data latch.
- Scoreboard: slots EX, MEM and WB, each holding {valid, dst, regwrite, is_load}. A slot is a producer only if valid, regwrite and dst != 0.
- Distance from the ID instruction: EX slot = d1, MEM slot = d2, WB slot = d3.
- Forward select for a used source (computed combinationally in ID, registered into fwd_a/fwd_b on advance):
  - Matches d1 → 01.
  - Otherwise matches d2 → 10.
  - Otherwise matches d3 → 11.
  - Otherwise 00.
  - Nearest producer wins. Register 0 and unused sources always give 00.
- Load-use stall: asserted when id_valid and the d1 producer is a load whose dst matches a used source.
- HI/LO stall: asserted when id_valid, (id_muldiv or id_hilo_rd), and muldiv_busy.
- stall is combinational from the current state and ID inputs; it is forced to 0 when flush or hold is 1.
- Advance occurs on every clk edge where hold = 0:
  - WB ← MEM, MEM ← EX.
  - EX ← ID info when id_valid, !stall and !flush; otherwise EX ← bubble (valid = 0).
  - fwd_a/fwd_b ← computed selects for an issued instruction; 00 for a bubble.
- When hold = 1: scoreboard and fwd registers keep their values.
- Busy counter:
  - Loads MULDIV_CYCLES when a mul/div issues (advance, id_valid, id_muldiv, !stall, !flush).
  - Otherwise decrements when nonzero, including during hold.
  - muldiv_busy = (counter != 0).
- Simultaneous flush and stall condition: flush wins, bubble issued, stall = 0.
- Reset:
  - All slots invalid; fwd_a = fwd_b = 00; counter = 0; stall = 0; muldiv_busy = 0.
  - Reset overrides hold.
  - Reset mid-stall or mid-mul/div clears all state in one cycle.
- Latency: a producer's effect on the selects is visible on the next ID instruction in the same cycle. fwd_* are valid one cycle after issue, aligned with the instruction's EX cycle.

Decomposition:
- Shared package constants: FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, FWD_WBLAT = 2'b11.
- Shared package: scoreboard slot field widths.
- Natural sub-module: fwd_sel_calc (combinational priority compare of one source against the three slots). Instantiate twice, for rs and rt.

Test Plan:
- add $3,$1,$2 then add $4,$3,$3 back-to-back → stall = 0; next cycle fwd_a = fwd_b = 01.
- add $3 then one nop then sub $5,$3,$0 → fwd_a = 10, fwd_b = 00; with two nops → fwd_a = 11; with three nops → 00.
- lw $7 then add $8,$7,$1 → stall = 1 for exactly one cycle, bubble enters EX; then add issues with fwd_a = 10.
- Writes to $0 followed by a read of $0 → no stall, fwd = 00. Flush asserted during a load-use condition → stall = 0, bubble issued.
- mult issues, then mflo next cycle with MULDIV_CYCLES = 4 → stall held 4 cycles, mflo issues when muldiv_busy falls.
- hold = 1 for 3 cycles mid-sequence → fwd/scoreboard frozen; reset asserted during a stall → all outputs 00/0 next cycle.
